flag_hazard_scoreboard: RTL

- Parametrised successor to the combinational branch flag-hazard check.
- Keeps its own shift-register scoreboard of pending flag writers, DEPTH stages deep (stage 0 = EX, last stage = WB), instead of decoding stage opcodes.
- Stalls a branch in ID while any needed flag is still in flight before WB.
- Raises per-flag bypass when the needed flag sits in WB.
- Adds a stall-length counter and a sticky watchdog error.

---
 rtl/flag_hazard_scoreboard.sv | 126 ++++++++++++
 1 files changed

// File: rtl/flag_hazard_scoreboard.sv
// Branch flag-hazard scoreboard: shift-register tracking of in-flight flag writers.
// Optional perf counters enabled by defining FLAG_HAZ_PERF_EN.
module flag_hazard_scoreboard #(
  parameter int NUM_FLAGS    = 3,
  parameter int DEPTH        = 3,
  parameter int FLUSH_STAGES = 1,
  parameter int CNT_W        = 4,
  parameter int MAX_STALL    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipe_advance,
  input  logic                 issue_valid,
  input  logic [NUM_FLAGS-1:0] issue_flag_mask,
  input  logic                 flush,
  input  logic                 id_branch,
  input  logic [NUM_FLAGS-1:0] id_need_mask,
  output logic                 stall,
  output logic [NUM_FLAGS-1:0] bypass_mask,
  output logic [NUM_FLAGS-1:0] pending_mask,
  output logic [CNT_W-1:0]     stall_len,
  output logic                 stall_err
`ifdef FLAG_HAZ_PERF_EN
  ,
  output logic [31:0]          perf_branches,
  output logic [31:0]          perf_stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ERR_LEN = CNT_W'(MAX_STALL);

  logic [NUM_FLAGS-1:0] sb_q [DEPTH];
  logic [NUM_FLAGS-1:0] sb_d [DEPTH];
  logic [NUM_FLAGS-1:0] inflight;
  logic [NUM_FLAGS-1:0] wb_flags;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 err_q;
  logic                 err_hit;

  // Everything before WB is still unresolved; WB can be forwarded.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      inflight = inflight | sb_q[i];
    end
  end

  assign wb_flags     = sb_q[DEPTH-1];
  assign pending_mask = inflight | wb_flags;

  assign stall = id_branch ? |(id_need_mask & inflight) : 1'b0;

  assign bypass_mask = (id_branch && !stall)
                     ? (id_need_mask & wb_flags)
                     : '0;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sb_d[i] = sb_q[i];
    end
    if (pipe_advance) begin
      sb_d[0] = (issue_valid && !stall) ? issue_flag_mask : '0;
      for (int i = 1; i < DEPTH; i++) begin
        sb_d[i] = sb_q[i-1];
      end
    end
    // Flush acts on the post-shift state, so a same-cycle issue is dropped.
    if (flush) begin
      for (int i = 0; i < FLUSH_STAGES; i++) begin
        sb_d[i] = '0;
      end
    end
  end

  // cnt_q holds completed stall cycles; the visible length includes this one.
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign stall_len = stall ? cnt_inc : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (!stall) begin
      cnt_d = '0;
    end else if (pipe_advance) begin
      cnt_d = cnt_inc;
    end
  end

  assign err_hit   = (stall_len == ERR_LEN);
  assign stall_err = err_q | err_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_q[i] <= '0;
      end
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_q[i] <= sb_d[i];
      end
      cnt_q <= cnt_d;
      err_q <= err_q | err_hit;
    end
  end

`ifdef FLAG_HAZ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (id_branch && !stall && pipe_advance) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (stall && pipe_advance) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
